// File: rtl/case_1_sdiv_pkg.sv
// case_1_sdiv_pkg: shared FSM state type and divide-by-zero quotient fill for the sequential signed divider.
package case_1_sdiv_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
  localparam logic DBZ_QUOT_BIT = 1'b1;
endpackage

// File: rtl/case_1_sdiv_step.sv
// case_1_sdiv_step: one restoring-division iteration (shift in a dividend bit, trial subtract, select).
module case_1_sdiv_step #(
  parameter int RW = 6
) (
  input  logic [RW-1:0] rem_in,
  input  logic          bit_in,
  input  logic [RW:0]   divisor,
  output logic [RW-1:0] rem_out,
  output logic          q_bit
);
  logic [RW:0] sh, diff;
  always_comb begin
    sh = {rem_in, bit_in};
    diff = sh - divisor;
    q_bit = sh >= divisor;
    rem_out = RW'(q_bit ? diff : sh);
  end
endmodule

// File: rtl/case_1_sdiv_seq.sv
// case_1_sdiv_seq: sequential signed divider, DIVIDEND_WIDTH+1 cycles per result, valid/ready handshakes.
// Define CASE_1_SDIV_DIVZERO_FLAG_EN to add the dbz output flagging a zero divisor.
module case_1_sdiv_seq
  import case_1_sdiv_pkg::*;
#(
  parameter int ID = 1,
  parameter int DIVIDEND_WIDTH = 11,
  parameter int DIVISOR_WIDTH = 6
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      din_valid,
  output logic                      din_ready,
  input  logic [DIVIDEND_WIDTH-1:0] din0,
  input  logic [DIVISOR_WIDTH-1:0]  din1,
  output logic                      dout_valid,
  input  logic                      dout_ready,
`ifdef CASE_1_SDIV_DIVZERO_FLAG_EN
  output logic                      dbz,
`endif
  output logic [DIVIDEND_WIDTH-1:0] quot,
  output logic [DIVISOR_WIDTH-1:0]  rem
);
  localparam int W = DIVIDEND_WIDTH;
  localparam int D = DIVISOR_WIDTH;
  localparam int CW = $clog2(W + 1) + 0 * ID;
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0] a_q, a_d, a_ext;
  logic [D:0] b_q, b_d, b_ext;
  logic [D-1:0] pr_q, pr_d, step_r;
  logic [W-1:0] qm_q, qm_d;
  logic step_q;
  logic qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
  logic din_ready_q, din_ready_d, dout_valid_q, dout_valid_d;
  logic [W-1:0] quot_q, quot_d;
  logic [D-1:0] rem_q, rem_d;

  case_1_sdiv_step #(.RW(D)) u_step (
    .rem_in (pr_q),
    .bit_in (a_q[W-1]),
    .divisor(b_q),
    .rem_out(step_r),
    .q_bit  (step_q)
  );

  always_comb begin
    a_ext = {din0[W-1], din0};
    b_ext = {din1[D-1], din1};
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    pr_d = pr_q;
    qm_d = qm_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    zero_d = zero_q;
    dout_valid_d = dout_valid_q;
    quot_d = quot_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (din_valid && din_ready_q) begin
        state_d = CALC;
        cnt_d = '0;
        a_d = a_ext[W] ? -a_ext : a_ext;
        b_d = b_ext[D] ? -b_ext : b_ext;
        pr_d = '0;
        qm_d = '0;
        qneg_d = din0[W-1] ^ din1[D-1];
        rneg_d = din0[W-1];
        zero_d = din1 == '0;
      end
      CALC: if (cnt_q == CW'(W)) begin
        state_d = DONE;
        dout_valid_d = 1'b1;
        quot_d = zero_q ? {W{DBZ_QUOT_BIT}} : (qneg_q ? -qm_q : qm_q);
        rem_d = zero_q ? '0 : (rneg_q ? -pr_q : pr_q);
      end else begin
        cnt_d = cnt_q + 1'b1;
        a_d = a_q << 1;
        pr_d = step_r;
        qm_d = {qm_q[W-2:0], step_q};
      end
      DONE: if (dout_ready) begin
        state_d = IDLE;
        dout_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    din_ready_d = state_d == IDLE;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      pr_q <= '0;
      qm_q <= '0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      zero_q <= 1'b0;
      din_ready_q <= 1'b0;
      dout_valid_q <= 1'b0;
      quot_q <= '0;
      rem_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      pr_q <= pr_d;
      qm_q <= qm_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      zero_q <= zero_d;
      din_ready_q <= din_ready_d;
      dout_valid_q <= dout_valid_d;
      quot_q <= quot_d;
      rem_q <= rem_d;
    end
  end

  assign din_ready = din_ready_q;
  assign dout_valid = dout_valid_q;
  assign quot = quot_q;
  assign rem = rem_q;
`ifdef CASE_1_SDIV_DIVZERO_FLAG_EN
  assign dbz = dout_valid_q & zero_q;
`endif
endmodule

// File: tb/tb_case_1_sdiv_seq.sv
// tb_case_1_sdiv_seq: randomized scoreboard bench for case_1_sdiv_seq against an integer-arithmetic reference.
module tb_case_1_sdiv_seq;
  localparam int W = 11;
  localparam int D = 6;
  localparam int LAT = W + 1;
  typedef struct {
    logic [W-1:0] q;
    logic [D-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  logic ap_clk = 1'b0, ap_rst_n = 1'b0, din_valid = 1'b0, dout_ready = 1'b0;
  logic din_ready, dout_valid;
  logic [W-1:0] din0 = '0, quot;
  logic [D-1:0] din1 = '0, rem;
`ifdef CASE_1_SDIV_DIVZERO_FLAG_EN
  logic dbz;
`endif
  int n_cmp = 0, n_bad = 0, cyc = 0;
  exp_t sb[$];
  bit prev_v = 0, first = 1;
  int hold = 0;
  logic [W-1:0] q0;
  logic [D-1:0] r0;
  exp_t me, dropped;
  logic signed [W-1:0] ra;
  logic signed [D-1:0] rb;

  case_1_sdiv_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din0      (din0),
    .din1      (din1),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
`ifdef CASE_1_SDIV_DIVZERO_FLAG_EN
    .dbz       (dbz),
`endif
    .quot      (quot),
    .rem       (rem)
  );

  always #5 ap_clk = ~ap_clk;
  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.acc = 0;
    if (b == 0) begin
      e.q = '1;
      e.r = '0;
      e.z = 1'b1;
    end else begin
      e.q = W'(a / b);
      e.r = D'(a % b);
      e.z = 1'b0;
    end
    return e;
  endfunction

  task automatic issue(input int a, input int b, input int garble);
    int n = 0;
    exp_t e;
    @(negedge ap_clk);
    while (din_ready !== 1'b1 && n < 400) begin
      @(negedge ap_clk);
      n++;
    end
    if (din_ready !== 1'b1) begin
      chk("din_ready_wait", {31'd0, din_ready}, 1);
      return;
    end
    din0 = W'(a);
    din1 = D'(b);
    din_valid = 1'b1;
    @(posedge ap_clk);
    #1;
    e = model(a, b);
    e.acc = cyc;
    sb.push_back(e);
    for (int i = 0; i < garble; i++) begin
      din_valid = 1'($urandom);
      din0 = W'($urandom);
      din1 = D'($urandom);
      @(negedge ap_clk);
    end
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || dout_valid) && n < 3000) begin
      @(negedge ap_clk);
      n++;
    end
    chk("drain_queue", sb.size(), 0);
  endtask

  // Monitor: compares each result when it first appears, then checks it holds under back-pressure.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (!ap_rst_n) begin
        prev_v = 0;
        dout_ready = 1'b0;
        continue;
      end
      if (dout_valid) begin
        if (!prev_v) begin
          if (sb.size() == 0) chk("unexpected_result", {31'd0, dout_valid}, 0);
          else begin
            me = sb.pop_front();
            chk("quot", quot, me.q);
            chk("rem", rem, me.r);
            chk("latency", cyc - me.acc, LAT);
`ifdef CASE_1_SDIV_DIVZERO_FLAG_EN
            chk("dbz", dbz, me.z);
`endif
          end
          q0 = quot;
          r0 = rem;
          hold = first ? 5 : $urandom_range(0, 3);
          first = 0;
        end else begin
          chk("hold_quot", quot, q0);
          chk("hold_rem", rem, r0);
          chk("hold_din_ready", din_ready, 0);
          hold--;
        end
        dout_ready = hold == 0;
      end else if (prev_v) begin
        chk("din_ready_after_handshake", din_ready, 1);
        dout_ready = 1'b0;
      end
      prev_v = dout_valid;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_din_ready", din_ready, 0);
    chk("rst_dout_valid", dout_valid, 0);
    chk("rst_quot", quot, 0);
    chk("rst_rem", rem, 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("din_ready_after_reset", din_ready, 1);
    issue(100, 7, 8);
    issue(-100, 7, 8);
    issue(100, -7, 0);
    issue(-100, -7, 8);
    issue(-1024, -1, 8);
    issue(5, 0, 8);
    for (int k = 0; k < 40; k++) begin
      ra = W'($urandom);
      rb = D'($urandom);
      if ($urandom_range(0, 7) == 0) ra = {1'b1, {(W-1){1'b0}}};
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = '1;
        2: rb = {1'b1, {(D-1){1'b0}}};
        default: ;
      endcase
      issue(int'(ra), int'(rb), $urandom_range(0, 8));
    end
    drain();
    issue(77, 3, 0);
    repeat (5) @(posedge ap_clk);
    @(negedge ap_clk);
    ap_rst_n = 1'b0;
    #1;
    chk("abort_dout_valid", dout_valid, 0);
    chk("abort_din_ready", din_ready, 0);
    chk("abort_quot", quot, 0);
    chk("abort_rem", rem, 0);
    if (sb.size() != 0) dropped = sb.pop_back();
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("din_ready_after_abort", din_ready, 1);
    issue(63, 8, 8);
    drain();
    repeat (30) @(negedge ap_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
